// File: rtl/oflow_iou_match_sched_if.sv
// ---------------------------------------------------------------------------
// oflow_iou_match_sched_if
// Bundles every non-clock, non-reset signal of the IoU match scheduler:
//   - job request side   : start_i, bbox_k_i, w_k_i, h_k_i, hist_cnt_i, thresh_i, busy_o
//   - history memory side: hist_rd_en_o, hist_rd_addr_o, hist_rd_data_i
//   - IoU engine side    : eng_start_o, eng_*_o operands, eng_done_i, eng_iou_i
//   - job result         : done_o, match_valid_o, best_idx_o, best_iou_o, timeout_err_o
// Modport slave is the scheduler itself; modport master is its environment
// (frame controller, history memory and IoU engine together).
// ---------------------------------------------------------------------------
interface oflow_iou_match_sched_if #(
  parameter int IDX_W = 5
);
  // job request
  logic              start_i;
  logic [43:0]       bbox_k_i;
  logic [10:0]       w_k_i;
  logic [10:0]       h_k_i;
  logic [IDX_W:0]    hist_cnt_i;
  logic [21:0]       thresh_i;
  logic              busy_o;
  // history memory
  logic              hist_rd_en_o;
  logic [IDX_W-1:0]  hist_rd_addr_o;
  logic [65:0]       hist_rd_data_i;
  // IoU engine
  logic              eng_start_o;
  logic [43:0]       eng_bbox_k_o;
  logic [10:0]       eng_w_k_o;
  logic [10:0]       eng_h_k_o;
  logic [43:0]       eng_bbox_h_o;
  logic [10:0]       eng_w_h_o;
  logic [10:0]       eng_h_h_o;
  logic              eng_done_i;
  logic [21:0]       eng_iou_i;
  // job result
  logic              done_o;
  logic              match_valid_o;
  logic [IDX_W-1:0]  best_idx_o;
  logic [21:0]       best_iou_o;
  logic              timeout_err_o;

  modport slave (
    input  start_i, bbox_k_i, w_k_i, h_k_i, hist_cnt_i, thresh_i,
    input  hist_rd_data_i, eng_done_i, eng_iou_i,
    output busy_o, hist_rd_en_o, hist_rd_addr_o,
    output eng_start_o, eng_bbox_k_o, eng_w_k_o, eng_h_k_o,
    output eng_bbox_h_o, eng_w_h_o, eng_h_h_o,
    output done_o, match_valid_o, best_idx_o, best_iou_o, timeout_err_o
  );

  modport master (
    output start_i, bbox_k_i, w_k_i, h_k_i, hist_cnt_i, thresh_i,
    output hist_rd_data_i, eng_done_i, eng_iou_i,
    input  busy_o, hist_rd_en_o, hist_rd_addr_o,
    input  eng_start_o, eng_bbox_k_o, eng_w_k_o, eng_h_k_o,
    input  eng_bbox_h_o, eng_w_h_o, eng_h_h_o,
    input  done_o, match_valid_o, best_idx_o, best_iou_o, timeout_err_o
  );
endinterface

// File: rtl/oflow_iou_match_sched.sv
// ---------------------------------------------------------------------------
// oflow_iou_match_sched
// Sequences one shared IoU engine across all valid history bboxes for a single
// frame-k bbox and reports the history entry with the lowest IoU distance.
//
// Ports:
//   clk      - clock
//   reset_N  - asynchronous reset, active-high
//   bus      - oflow_iou_match_sched_if.slave: job request, history memory
//              read port, IoU engine start/done handshake and job result.
//
// Per entry: FETCH -> WAIT_RD -> ISSUE -> WAIT_ENG -> UPDATE (4 + L cycles,
// L = ISSUE-to-done latency). A job with zero entries goes straight to REPORT.
// Result registers are loaded on the edge that enters REPORT so they are
// already valid in the cycle done_o is high, and then hold until the next job
// reports. IDX_W must satisfy 2**IDX_W >= HIST_DEPTH.
// ---------------------------------------------------------------------------
module oflow_iou_match_sched #(
  parameter int HIST_DEPTH = 32,
  parameter int IDX_W      = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset_N,
  oflow_iou_match_sched_if.slave bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(HIST_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [21:0]      IOU_WORST = 22'h3FFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_ENG,
    S_UPDATE,
    S_REPORT
  } state_t;

  state_t state_reg, state_next;

  // job operands latched at start
  logic [43:0]      bbox_k_reg;
  logic [10:0]      w_k_reg, h_k_reg;
  logic [21:0]      thresh_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] idx_reg;
  // history operands for the entry currently in the engine
  logic [43:0]      bbox_h_reg;
  logic [10:0]      w_h_reg, h_h_reg;
  // running search state
  logic [21:0]      iou_reg;
  logic [21:0]      best_iou_reg;
  logic [IDX_W-1:0] best_idx_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_err_reg;
  // published result
  logic [IDX_W-1:0] out_idx_reg;
  logic [21:0]      out_iou_reg;
  logic             out_match_reg;

  // combinational helpers
  logic [CNT_W-1:0] cnt_clamped;
  logic [CNT_W-1:0] idx_inc;
  logic             better;
  logic [21:0]      upd_best_iou;
  logic [IDX_W-1:0] upd_best_idx;
  logic             tmo_hit;
  logic [21:0]      rep_iou;
  logic [IDX_W-1:0] rep_idx;
  logic             rep_match;

  assign cnt_clamped  = (bus.hist_cnt_i > DEPTH_C) ? DEPTH_C : bus.hist_cnt_i;
  assign idx_inc      = idx_reg + CNT_W'(1);
  // strict compare: equal scores keep the earlier (lower) index
  assign better       = (iou_reg < best_iou_reg);
  assign upd_best_iou = better ? iou_reg : best_iou_reg;
  assign upd_best_idx = better ? idx_reg[IDX_W-1:0] : best_idx_reg;
  assign tmo_hit      = (tmo_cnt_reg == TMO_LAST);

  // ---------------------------------------------------------------------
  // state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // next state and the result to publish when entering REPORT
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    rep_iou    = best_iou_reg;
    rep_idx    = best_idx_reg;
    rep_match  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.start_i) begin
          if (cnt_clamped == '0) begin
            // empty history: report the initial "no match" score
            state_next = S_REPORT;
            rep_iou    = IOU_WORST;
            rep_idx    = '0;
            rep_match  = 1'b0;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_FETCH:   state_next = S_WAIT_RD;
      S_WAIT_RD: state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT_ENG;
      S_WAIT_ENG: begin
        if (bus.eng_done_i) begin
          state_next = S_UPDATE;
        end else if (tmo_hit) begin
          // aborted job never reports a match
          state_next = S_REPORT;
        end
      end
      S_UPDATE: begin
        if (idx_inc == cnt_reg) begin
          state_next = S_REPORT;
          rep_iou    = upd_best_iou;
          rep_idx    = upd_best_idx;
          rep_match  = (upd_best_iou <= thresh_reg);
        end else begin
          state_next = S_FETCH;
        end
      end
      S_REPORT:  state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      bbox_k_reg      <= '0;
      w_k_reg         <= '0;
      h_k_reg         <= '0;
      thresh_reg      <= '0;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      bbox_h_reg      <= '0;
      w_h_reg         <= '0;
      h_h_reg         <= '0;
      iou_reg         <= '0;
      best_iou_reg    <= IOU_WORST;
      best_idx_reg    <= '0;
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
      out_idx_reg     <= '0;
      out_iou_reg     <= '0;
      out_match_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start_i) begin
            bbox_k_reg      <= bus.bbox_k_i;
            w_k_reg         <= bus.w_k_i;
            h_k_reg         <= bus.h_k_i;
            thresh_reg      <= bus.thresh_i;
            cnt_reg         <= cnt_clamped;
            idx_reg         <= '0;
            best_iou_reg    <= IOU_WORST;
            best_idx_reg    <= '0;
            timeout_err_reg <= 1'b0;
          end
        end
        S_WAIT_RD: begin
          bbox_h_reg <= bus.hist_rd_data_i[65:22];
          w_h_reg    <= bus.hist_rd_data_i[21:11];
          h_h_reg    <= bus.hist_rd_data_i[10:0];
        end
        S_ISSUE: begin
          tmo_cnt_reg <= '0;
        end
        S_WAIT_ENG: begin
          if (bus.eng_done_i) begin
            iou_reg <= bus.eng_iou_i;
          end else if (tmo_hit) begin
            timeout_err_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        S_UPDATE: begin
          best_iou_reg <= upd_best_iou;
          best_idx_reg <= upd_best_idx;
          idx_reg      <= idx_inc;
        end
        default: ;
      endcase

      if (state_next == S_REPORT) begin
        out_iou_reg   <= rep_iou;
        out_idx_reg   <= rep_idx;
        out_match_reg <= rep_match;
      end
    end
  end

  // ---------------------------------------------------------------------
  // outputs; strobes decode directly from the state so reset clears them
  // at once
  // ---------------------------------------------------------------------
  assign bus.busy_o         = (state_reg != S_IDLE);
  assign bus.hist_rd_en_o   = (state_reg == S_FETCH);
  assign bus.hist_rd_addr_o = idx_reg[IDX_W-1:0];
  assign bus.eng_start_o    = (state_reg == S_ISSUE);
  assign bus.eng_bbox_k_o   = bbox_k_reg;
  assign bus.eng_w_k_o      = w_k_reg;
  assign bus.eng_h_k_o      = h_k_reg;
  assign bus.eng_bbox_h_o   = bbox_h_reg;
  assign bus.eng_w_h_o      = w_h_reg;
  assign bus.eng_h_h_o      = h_h_reg;
  assign bus.done_o         = (state_reg == S_REPORT);
  assign bus.match_valid_o  = out_match_reg;
  assign bus.best_idx_o     = out_idx_reg;
  assign bus.best_iou_o     = out_iou_reg;
  assign bus.timeout_err_o  = timeout_err_reg;

endmodule

// File: tb/tb_oflow_iou_match_sched.sv
// ---------------------------------------------------------------------------
// tb_oflow_iou_match_sched
// Directed bench for oflow_iou_match_sched. Behavioural models of the history
// memory (one-cycle read latency) and of the IoU engine (fixed latency, results
// from a table) surround the DUT; the stimulus is one linear initial block.
// Cycle numbers are counted from the start-accept cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_oflow_iou_match_sched;

  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic reset_N;
  int   cyc = 0;

  oflow_iou_match_sched_if #(.IDX_W(IDX_W)) bus ();

  oflow_iou_match_sched #(
    .HIST_DEPTH(32),
    .IDX_W     (IDX_W),
    .TIMEOUT   (64)
  ) dut (
    .clk    (clk),
    .reset_N(reset_N),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // history entry i: bbox {i, i+1, i+2, i+3}, w = i+10, h = i+20
  function automatic logic [65:0] mem_word(input int i);
    return {11'(i), 11'(i + 1), 11'(i + 2), 11'(i + 3), 11'(i + 10), 11'(i + 20)};
  endfunction

  // history memory model: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.hist_rd_en_o) bus.hist_rd_data_i <= mem_word(int'(bus.hist_rd_addr_o));
  end

  // IoU engine model: done eng_lat cycles after the start cycle
  int eng_lat = 1;
  bit eng_en  = 1'b1;
  int eng_k   = 0;
  int eng_cnt = 0;
  int iou_tbl [0:63];
  always @(negedge clk) begin
    bus.eng_done_i = 1'b0;
    if (bus.eng_start_o) begin
      eng_cnt = eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0 && eng_en) begin
        bus.eng_done_i = 1'b1;
        bus.eng_iou_i  = 22'(iou_tbl[eng_k]);
        eng_k = eng_k + 1;
      end
    end
  end

  // monitor
  int          rd_addr_q [$];
  int          st_cyc_q  [$];
  logic [43:0] hbox_q    [$];
  logic [10:0] hw_q      [$];
  int          done_total = 0;
  always @(negedge clk) begin
    if (bus.hist_rd_en_o) rd_addr_q.push_back(int'(bus.hist_rd_addr_o));
    if (bus.eng_start_o) begin
      st_cyc_q.push_back(cyc);
      hbox_q.push_back(bus.eng_bbox_h_o);
      hw_q.push_back(bus.eng_w_h_o);
    end
    if (bus.done_o) done_total = done_total + 1;
  end

  int total = 0;
  int bad   = 0;
  int t0;
  int done_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one job and waits (bounded) for done_o; rel = done cycle or -1.
  // mid_start >= 0 pulses start_i that many cycles into the job.
  task automatic run_job(input int n, input int th, input int lat, input bit en,
                         input int mid_start, output int rel);
    @(negedge clk);
    rd_addr_q.delete();
    st_cyc_q.delete();
    hbox_q.delete();
    hw_q.delete();
    eng_k     = 0;
    eng_lat   = lat;
    eng_en    = en;
    done_base = done_total;
    bus.hist_cnt_i = 6'(n);
    bus.thresh_i   = 22'(th);
    bus.start_i    = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
    rel = -1;
    for (int i = 1; i < 600; i++) begin
      if (bus.done_o) begin
        rel = cyc - t0;
        break;
      end
      bus.start_i = (i == mid_start);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int rel;
  bit seq_ok;

  initial begin
    reset_N            = 1'b1;
    bus.start_i        = 1'b0;
    bus.bbox_k_i       = 44'h123456789AB;
    bus.w_k_i          = 11'h155;
    bus.h_k_i          = 11'h2AA;
    bus.hist_cnt_i     = '0;
    bus.thresh_i       = '0;
    bus.hist_rd_data_i = '0;
    bus.eng_done_i     = 1'b0;
    bus.eng_iou_i      = '0;
    for (int i = 0; i < 64; i++) iou_tbl[i] = 0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy",   64'(bus.busy_o), 64'd0);
    chk("rst_done",   64'(bus.done_o), 64'd0);
    chk("rst_best",   64'(bus.best_iou_o), 64'd0);
    chk("rst_rd_en",  64'(bus.hist_rd_en_o), 64'd0);
    chk("rst_tmo",    64'(bus.timeout_err_o), 64'd0);
    reset_N = 1'b0;
    @(negedge clk);

    // job 1: N=3, L=8, iou {300,120,500}, thresh 200
    iou_tbl[0] = 300; iou_tbl[1] = 120; iou_tbl[2] = 500;
    run_job(3, 200, 8, 1'b1, -1, rel);
    $display("job1: done_cyc=%0d idx=%0d iou=%0d match=%0d", rel, bus.best_idx_o, bus.best_iou_o, bus.match_valid_o);
    chk("j1_done_cyc", 64'(rel), 64'd37);
    chk("j1_best_idx", 64'(bus.best_idx_o), 64'd1);
    chk("j1_best_iou", 64'(bus.best_iou_o), 64'd120);
    chk("j1_match",    64'(bus.match_valid_o), 64'd1);
    chk("j1_reads",    64'(rd_addr_q.size()), 64'd3);
    seq_ok = (rd_addr_q.size() == 3) && rd_addr_q[0] == 0 && rd_addr_q[1] == 1 && rd_addr_q[2] == 2;
    chk("j1_addr_seq", 64'(seq_ok), 64'd1);
    chk("j1_starts",   64'(st_cyc_q.size()), 64'd3);
    chk("j1_start0",   64'(st_cyc_q[0] - t0), 64'd3);
    chk("j1_start1",   64'(st_cyc_q[1] - t0), 64'd15);
    chk("j1_start2",   64'(st_cyc_q[2] - t0), 64'd27);
    chk("j1_hbox1",    64'(hbox_q[1]), 64'(mem_word(1) >> 22));
    chk("j1_hw1",      64'(hw_q[1]), 64'd11);
    chk("j1_bbox_k",   64'(bus.eng_bbox_k_o), 64'h123456789AB);
    @(negedge clk);
    chk("j1_done_pulse", 64'(bus.done_o), 64'd0);
    chk("j1_idle",       64'(bus.busy_o), 64'd0);
    chk("j1_hold_iou",   64'(bus.best_iou_o), 64'd120);

    // job 2: N=0 -> done one cycle after accept (cycle 2 counting accept as 1)
    run_job(0, 200, 8, 1'b1, -1, rel);
    $display("job2: done_cyc=%0d idx=%0d iou=%0h match=%0d", rel, bus.best_idx_o, bus.best_iou_o, bus.match_valid_o);
    chk("j2_done_cyc", 64'(rel), 64'd1);
    chk("j2_match",    64'(bus.match_valid_o), 64'd0);
    chk("j2_best_iou", 64'(bus.best_iou_o), 64'h3FFFFF);
    chk("j2_best_idx", 64'(bus.best_idx_o), 64'd0);
    chk("j2_reads",    64'(rd_addr_q.size()), 64'd0);
    chk("j2_starts",   64'(st_cyc_q.size()), 64'd0);

    // job 3: N=2, L=3, tie at 150, thresh 100
    iou_tbl[0] = 150; iou_tbl[1] = 150;
    run_job(2, 100, 3, 1'b1, -1, rel);
    $display("job3: done_cyc=%0d idx=%0d iou=%0d match=%0d", rel, bus.best_idx_o, bus.best_iou_o, bus.match_valid_o);
    chk("j3_done_cyc", 64'(rel), 64'd15);
    chk("j3_best_idx", 64'(bus.best_idx_o), 64'd0);
    chk("j3_best_iou", 64'(bus.best_iou_o), 64'd150);
    chk("j3_match",    64'(bus.match_valid_o), 64'd0);

    // job 4: N=2, engine silent -> abort after 64 WAIT_ENG cycles
    run_job(2, 100, 3, 1'b0, -1, rel);
    $display("job4: done_cyc=%0d tmo=%0d match=%0d", rel, bus.timeout_err_o, bus.match_valid_o);
    chk("j4_done_cyc", 64'(rel), 64'd68);
    chk("j4_tmo",      64'(bus.timeout_err_o), 64'd1);
    chk("j4_match",    64'(bus.match_valid_o), 64'd0);
    chk("j4_starts",   64'(st_cyc_q.size()), 64'd1);
    chk("j4_best_iou", 64'(bus.best_iou_o), 64'h3FFFFF);

    // job 5: hist_cnt 40 clamped to 32, L=1, iou = 1000-i, start pulsed mid-job
    for (int i = 0; i < 32; i++) iou_tbl[i] = 1000 - i;
    run_job(40, 2000, 1, 1'b1, 20, rel);
    $display("job5: done_cyc=%0d reads=%0d idx=%0d iou=%0d", rel, rd_addr_q.size(), bus.best_idx_o, bus.best_iou_o);
    chk("j5_done_cyc", 64'(rel), 64'd161);
    chk("j5_reads",    64'(rd_addr_q.size()), 64'd32);
    seq_ok = (rd_addr_q.size() == 32);
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != i) seq_ok = 1'b0;
    chk("j5_addr_seq", 64'(seq_ok), 64'd1);
    chk("j5_best_idx", 64'(bus.best_idx_o), 64'd31);
    chk("j5_best_iou", 64'(bus.best_iou_o), 64'd969);
    chk("j5_match",    64'(bus.match_valid_o), 64'd1);
    chk("j5_tmo_clr",  64'(bus.timeout_err_o), 64'd0);
    chk("j5_one_done", 64'(done_total - done_base), 64'd1);
    repeat (5) @(negedge clk);
    chk("j5_no_requeue", 64'(bus.busy_o), 64'd0);

    // job 6: reset asserted while waiting on the engine
    @(negedge clk);
    eng_en = 1'b0;
    done_base = done_total;
    st_cyc_q.delete();
    bus.hist_cnt_i = 6'd2;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("j6_in_wait",  64'(bus.busy_o), 64'd1);
    #2;
    reset_N = 1'b1;
    #1;
    $display("job6: reset mid-job busy=%0d done=%0d iou=%0d match=%0d", bus.busy_o, bus.done_o, bus.best_iou_o, bus.match_valid_o);
    chk("j6_busy",  64'(bus.busy_o), 64'd0);
    chk("j6_done",  64'(bus.done_o), 64'd0);
    chk("j6_iou",   64'(bus.best_iou_o), 64'd0);
    chk("j6_idx",   64'(bus.best_idx_o), 64'd0);
    chk("j6_match", 64'(bus.match_valid_o), 64'd0);
    chk("j6_start", 64'(bus.eng_start_o), 64'd0);
    @(negedge clk);
    reset_N = 1'b0;
    repeat (80) @(negedge clk);
    chk("j6_no_done", 64'(done_total - done_base), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
